// File: rtl/reg_arbiter_rr.sv
// Round-robin write arbiter sharing one N-bit register among four requesters, with lockable bursts.
// Latency: gnt is combinational in cycle t; q shows the granted port's data in cycle t+1.
// Backpressure: ungranted requests are not queued; requesters hold req until they see their gnt bit.
module reg_arbiter_rr #(
  parameter int N       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [3:0]     lock,
  input  logic [4*N-1:0] din,
  output logic [3:0]     gnt,
  output logic [N-1:0]   q,
  output logic [1:0]     owner,
  output logic           busy,
  output logic           timeout_evt
);

  typedef enum logic {IDLE, LOCKED} state_t;

  // The last count value at which a locked owner still holds the register
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t       state, state_nxt;
  logic [1:0]   ptr, ptr_nxt;
  logic [1:0]   owner_nxt;
  logic [7:0]   cnt, cnt_nxt;
  logic [N-1:0] q_nxt;
  logic         tevt_nxt;
  logic [1:0]   win;
  logic         win_vld;

  // Rotating priority scan: walk from the highest offset down so the first requester after ptr wins
  always_comb begin
    win     = ptr;
    win_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        win     = ptr + 2'(k);
        win_vld = 1'b1;
      end
    end
  end

  // Next-state, grant and register-write selection
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    q_nxt     = q;
    tevt_nxt  = 1'b0;
    gnt       = 4'b0000;
    case (state)
      IDLE: begin
        if (win_vld) begin
          gnt[win] = 1'b1;
          q_nxt    = din[int'(win) * N +: N];
          ptr_nxt  = win + 2'd1;
          if (lock[win]) begin
            state_nxt = LOCKED;
            owner_nxt = win;
            cnt_nxt   = 8'd1;
          end
        end
      end
      LOCKED: begin
        // Only the owner can write; an idle owned cycle still counts toward the timeout
        if (req[owner]) begin
          gnt[owner] = 1'b1;
          q_nxt      = din[int'(owner) * N +: N];
        end
        if (!lock[owner]) begin
          state_nxt = IDLE;
          ptr_nxt   = owner + 2'd1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          ptr_nxt   = owner + 2'd1;
          tevt_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // No grant is visible while reset is held, so nothing appears to be written
    if (rst) begin
      gnt = 4'b0000;
    end
  end

  // State register; reset aborts any lock without flagging a timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      owner       <= 2'd0;
      cnt         <= 8'd0;
      q           <= '0;
      timeout_evt <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      owner       <= owner_nxt;
      cnt         <= cnt_nxt;
      q           <= q_nxt;
      timeout_evt <= tevt_nxt;
    end
  end

  assign busy = (state == LOCKED);

endmodule

// File: tb/tb_reg_arbiter_rr.sv
// Scoreboarded directed bench for reg_arbiter_rr with N=8, TIMEOUT=4.
// Driver applies one vector per cycle and queues the hand-computed outputs for that cycle.
// Monitor pops one expectation per cycle on the falling edge and compares all outputs.
module tb_reg_arbiter_rr;

  localparam int N       = 8;
  localparam int TIMEOUT = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [3:0]     lock;
  logic [4*N-1:0] din;
  logic [3:0]     gnt;
  logic [N-1:0]   q;
  logic [1:0]     owner;
  logic           busy;
  logic           timeout_evt;

  typedef struct {
    int         idx;
    logic [3:0] gnt;
    logic [7:0] q;
    logic       busy;
    logic [1:0] owner;
    logic       tevt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  reg_arbiter_rr #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .lock        (lock),
    .din         (din),
    .gnt         (gnt),
    .q           (q),
    .owner       (owner),
    .busy        (busy),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] D0 = 32'h13121110;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, expv);
    end
  endtask

  // Apply one vector for a full cycle and queue what the outputs must show during it
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] lk, input logic [31:0] d,
                      input logic [3:0] eg, input logic [7:0] eq, input logic eb, input logic [1:0] eo,
                      input logic et);
    exp_t e;
    rst  = r;
    req  = rq;
    lock = lk;
    din  = d;
    e.idx   = vec_no;
    e.gnt   = eg;
    e.q     = eq;
    e.busy  = eb;
    e.owner = eo;
    e.tevt  = et;
    exp_q.push_back(e);
    vec_no++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt", e.idx, 32'(gnt), 32'(e.gnt));
        chk("q", e.idx, 32'(q), 32'(e.q));
        chk("busy", e.idx, 32'(busy), 32'(e.busy));
        chk("timeout_evt", e.idx, 32'(timeout_evt), 32'(e.tevt));
        if (e.busy) chk("owner", e.idx, 32'(owner), 32'(e.owner));
      end
    end
  end

  // Driver
  initial begin
    rst  = 1'b1;
    req  = 4'h0;
    lock = 4'h0;
    din  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    //    rst  req      lock     din           gnt      q      busy own tevt
    // Reset held with all requesting: no grant, q cleared
    step(1, 4'b1111, 4'b0000, D0,           4'b0000, 8'h00, 0, 0, 0);
    // Rotation from ptr=0
    step(0, 4'b1111, 4'b0000, D0,           4'b0001, 8'h00, 0, 0, 0);
    step(0, 4'b1111, 4'b0000, D0,           4'b0010, 8'h10, 0, 0, 0);
    step(0, 4'b1111, 4'b0000, D0,           4'b0100, 8'h11, 0, 0, 0);
    step(0, 4'b1111, 4'b0000, D0,           4'b1000, 8'h12, 0, 0, 0);
    step(0, 4'b1111, 4'b0000, D0,           4'b0001, 8'h13, 0, 0, 0);
    // Single requester moves ptr to 2
    step(0, 4'b0010, 4'b0000, D0,           4'b0010, 8'h10, 0, 0, 0);
    // Voluntary lock by port 2 while port 0 waits; three grant cycles then release
    step(0, 4'b0101, 4'b0100, D0,           4'b0100, 8'h11, 0, 0, 0);
    step(0, 4'b0101, 4'b0100, 32'h13AA1110, 4'b0100, 8'h12, 1, 2, 0);
    step(0, 4'b0101, 4'b0000, 32'h13BB1110, 4'b0100, 8'hAA, 1, 2, 0);
    // ptr=3 after release, port 3 idle so port 0 wins
    step(0, 4'b0001, 4'b0000, D0,           4'b0001, 8'hBB, 0, 0, 0);
    // Timeout: port 1 holds lock, port 3 waits; exactly four grant cycles
    step(0, 4'b1010, 4'b0010, D0,           4'b0010, 8'h10, 0, 0, 0);
    step(0, 4'b1010, 4'b0010, D0,           4'b0010, 8'h11, 1, 1, 0);
    step(0, 4'b1010, 4'b0010, D0,           4'b0010, 8'h11, 1, 1, 0);
    step(0, 4'b1010, 4'b0010, D0,           4'b0010, 8'h11, 1, 1, 0);
    step(0, 4'b1010, 4'b0010, D0,           4'b1000, 8'h11, 0, 0, 1);
    step(0, 4'b0010, 4'b0000, D0,           4'b0010, 8'h13, 0, 0, 0);
    // Idle owner: port 0 locks, drops req for two cycles, forced release on schedule
    step(0, 4'b0001, 4'b0001, D0,           4'b0001, 8'h11, 0, 0, 0);
    step(0, 4'b0000, 4'b0001, 32'h131211EE, 4'b0000, 8'h10, 1, 0, 0);
    step(0, 4'b0000, 4'b0001, 32'h131211EE, 4'b0000, 8'h10, 1, 0, 0);
    step(0, 4'b0001, 4'b0001, 32'h131211CC, 4'b0001, 8'h10, 1, 0, 0);
    step(0, 4'b0000, 4'b0000, D0,           4'b0000, 8'hCC, 0, 0, 1);
    // Reset mid-lock with cnt=2: lock aborted, no timeout pulse, ptr back to 0
    step(0, 4'b0100, 4'b0100, D0,           4'b0100, 8'hCC, 0, 0, 0);
    step(0, 4'b0100, 4'b0100, D0,           4'b0100, 8'h12, 1, 2, 0);
    step(1, 4'b0100, 4'b0100, D0,           4'b0000, 8'h12, 1, 2, 0);
    step(0, 4'b1111, 4'b0000, D0,           4'b0001, 8'h00, 0, 0, 0);
    step(0, 4'b0000, 4'b0000, D0,           4'b0000, 8'h10, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
